// File: rtl/pipeline_control_unit_pkg.sv
// pipeline_control_unit_pkg: shared state/select types and forwarding helper
package pipeline_control_unit_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} pipe_ctrl_state_t;
  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_LOAD = 2'b11
  } fwd_sel_t;
  function automatic fwd_sel_t fwdSel(input logic [4:0] src, input logic [4:0] memRw, input logic memWen,
                                      input logic memLoad, input logic [4:0] wbRw, input logic wbWen);
    return (src == 5'd0) ? FWD_REG :
           (memWen && src == memRw) ? (memLoad ? FWD_LOAD : FWD_MEM) :
           (wbWen && src == wbRw) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/pipeline_control_unit_forwarding.sv
// forwarding_unit: per-operand EX forwarding select, MEM producer beats WB
module forwarding_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [4:0] ex_Rs,
  input  logic [4:0] ex_Rt,
  input  logic [4:0] mem_Rw,
  input  logic       mem_RegWEN,
  input  logic       mem_dREN,
  input  logic [4:0] wb_Rw,
  input  logic       wb_RegWEN,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);
  // with forwarding disabled the operands always come from the register file
  always_comb begin
    fwd_a = (FWD_EN != 0) ? fwdSel(ex_Rs, mem_Rw, mem_RegWEN, mem_dREN, wb_Rw, wb_RegWEN) : FWD_REG;
    fwd_b = (FWD_EN != 0) ? fwdSel(ex_Rt, mem_Rw, mem_RegWEN, mem_dREN, wb_Rw, wb_RegWEN) : FWD_REG;
  end
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: latch enables/flushes, PC enable, halt drain FSM and stall counter
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_Rs,
  input  logic [4:0]       id_Rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_Rs,
  input  logic [4:0]       ex_Rt,
  input  logic [4:0]       ex_Rw,
  input  logic             ex_RegWEN,
  input  logic             ex_dREN,
  input  logic             branch_taken,
  input  logic [4:0]       mem_Rw,
  input  logic             mem_RegWEN,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic [4:0]       wb_Rw,
  input  logic             wb_RegWEN,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             em_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_ctrl_state_t state, nextState;
  logic dmemWait, useStall;
  function automatic logic idReads(input logic [4:0] rw, input logic wen);
    return wen && rw != 5'd0 && ((id_uses_rs && id_Rs == rw) || (id_uses_rt && id_Rt == rw));
  endfunction
  assign dmemWait = (mem_dREN | mem_dWEN) & ~dhit;
  assign useStall = idReads(ex_Rw, ex_RegWEN & ex_dREN) |
                    ((FWD_EN == 0) && (idReads(ex_Rw, ex_RegWEN) || idReads(mem_Rw, mem_RegWEN)));
  assign halt = (state == HALTED);
  forwarding_unit #(.FWD_EN(FWD_EN)) u_fwd (
    .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .mem_Rw(mem_Rw), .mem_RegWEN(mem_RegWEN),
    .mem_dREN(mem_dREN), .wb_Rw(wb_Rw), .wb_RegWEN(wb_RegWEN), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  // state register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= RUN;
    else state <= nextState;
  // hazard priority chain in RUN; DRAIN keeps bubbling until the halt retires
  always_comb begin
    nextState = state;
    pc_en = ihit;
    {fd_en, de_en, em_en, mw_en} = 4'b1111;
    {fd_flush, de_flush, em_flush} = 3'b000;
    if (state == HALTED) begin
      pc_en = 1'b0;
      {fd_en, de_en, em_en, mw_en} = 4'b0000;
    end else if (state == DRAIN) begin
      pc_en = 1'b0;
      {fd_en, de_en, em_en, mw_en} = {4{~dmemWait}};
      {fd_flush, de_flush, em_flush} = 3'b111;
      nextState = wb_halt ? HALTED : DRAIN;
    end else begin
      if (dmemWait) begin
        pc_en = 1'b0;
        {fd_en, de_en, em_en, mw_en} = 4'b0000;
      end else if (branch_taken) begin
        pc_en = 1'b1;
        {fd_flush, de_flush} = 2'b11;
      end else if (useStall) begin
        pc_en = 1'b0;
        fd_en = 1'b0;
        de_flush = 1'b1;
      end else if (!ihit) begin
        fd_flush = 1'b1;
      end
      nextState = (mem_halt && !dmemWait) ? DRAIN : RUN;
    end
  end
  // saturating count of RUN cycles in which the PC is held
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) stall_cnt <= '0;
    else if (state == RUN && !pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb_pipeline_control_unit: scoreboard bench for forwarding and no-forwarding/4-bit-counter variants
module tb_pipeline_control_unit;
  logic CLK = 1'b0;
  logic nRST, ihit, dhit, id_uses_rs, id_uses_rt, ex_RegWEN, ex_dREN, branch_taken;
  logic mem_RegWEN, mem_dREN, mem_dWEN, mem_halt, wb_RegWEN, wb_halt;
  logic [4:0] id_Rs, id_Rt, ex_Rs, ex_Rt, ex_Rw, mem_Rw, wb_Rw;
  logic aPc, aFd, aDe, aEm, aMw, aFdF, aDeF, aEmF, aHalt;
  logic bPc, bFd, bDe, bEm, bMw, bFdF, bDeF, bEmF, bHalt;
  logic [1:0] aFa, aFb, bFa, bFb;
  logic [15:0] aCnt;
  logic [3:0] bCnt;
  typedef struct {
    logic [7:0] ctl;
    logic [1:0] fa, fb;
    logic hlt;
    logic [15:0] cnt;
    logic [7:0] bCtl;
    logic [3:0] bCnt;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  localparam logic [7:0] IDLE = 8'b11111000, LU = 8'b00111010, WT = 8'b00000000, BR = 8'b11111110,
                         IW = 8'b01111100, DR = 8'b01111111, DRW = 8'b00000111;
  always #5 CLK = ~CLK;
  pipeline_control_unit #(.FWD_EN(1), .CNT_W(16)) dutA (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_Rs(id_Rs), .id_Rt(id_Rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_Rw(ex_Rw),
    .ex_RegWEN(ex_RegWEN), .ex_dREN(ex_dREN), .branch_taken(branch_taken), .mem_Rw(mem_Rw),
    .mem_RegWEN(mem_RegWEN), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .wb_Rw(wb_Rw), .wb_RegWEN(wb_RegWEN), .wb_halt(wb_halt), .pc_en(aPc), .fd_en(aFd), .de_en(aDe),
    .em_en(aEm), .mw_en(aMw), .fd_flush(aFdF), .de_flush(aDeF), .em_flush(aEmF), .fwd_a(aFa),
    .fwd_b(aFb), .halt(aHalt), .stall_cnt(aCnt)
  );
  pipeline_control_unit #(.FWD_EN(0), .CNT_W(4)) dutB (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_Rs(id_Rs), .id_Rt(id_Rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_Rw(ex_Rw),
    .ex_RegWEN(ex_RegWEN), .ex_dREN(ex_dREN), .branch_taken(branch_taken), .mem_Rw(mem_Rw),
    .mem_RegWEN(mem_RegWEN), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .wb_Rw(wb_Rw), .wb_RegWEN(wb_RegWEN), .wb_halt(wb_halt), .pc_en(bPc), .fd_en(bFd), .de_en(bDe),
    .em_en(bEm), .mw_en(bMw), .fd_flush(bFdF), .de_flush(bDeF), .em_flush(bEmF), .fwd_a(bFa),
    .fwd_b(bFb), .halt(bHalt), .stall_cnt(bCnt)
  );
  task automatic chk(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, vec, act, exp);
    end
  endtask
  // monitor: one expectation per cycle, compared mid-cycle
  int vec = 0;
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vec++;
      chk("a_ctl", vec, {aPc, aFd, aDe, aEm, aMw, aFdF, aDeF, aEmF}, e.ctl);
      chk("a_fwd_a", vec, aFa, e.fa);
      chk("a_fwd_b", vec, aFb, e.fb);
      chk("a_halt", vec, aHalt, e.hlt);
      chk("a_stall_cnt", vec, aCnt, e.cnt);
      chk("b_ctl", vec, {bPc, bFd, bDe, bEm, bMw, bFdF, bDeF, bEmF}, e.bCtl);
      chk("b_fwd", vec, {bFa, bFb}, 4'b0000);
      chk("b_halt", vec, bHalt, e.hlt);
      chk("b_stall_cnt", vec, bCnt, e.bCnt);
    end
  end
  task automatic apply(input logic [7:0] ctl, input logic [1:0] fa, input logic [1:0] fb, input logic hlt,
                       input logic [15:0] cnt, input logic [7:0] bc, input logic [3:0] bn);
    sb.push_back('{ctl: ctl, fa: fa, fb: fb, hlt: hlt, cnt: cnt, bCtl: bc, bCnt: bn});
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    {ihit, dhit, id_uses_rs, id_uses_rt, ex_RegWEN, ex_dREN, branch_taken} = 7'b1000000;
    {mem_RegWEN, mem_dREN, mem_dWEN, mem_halt, wb_RegWEN, wb_halt} = 6'b0;
    {id_Rs, id_Rt, ex_Rs, ex_Rt, ex_Rw, mem_Rw, wb_Rw} = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    nRST = 1'b0;
    idle();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    apply(IDLE, 0, 0, 0, 0, IDLE, 0);
    ex_dREN = 1; ex_Rw = 5; ex_RegWEN = 1; id_Rs = 5; id_uses_rs = 1;
    apply(LU, 0, 0, 0, 0, LU, 0);
    idle();
    apply(IDLE, 0, 0, 0, 1, IDLE, 1);
    ex_Rs = 3; mem_Rw = 3; mem_RegWEN = 1; wb_Rw = 3; wb_RegWEN = 1;
    apply(IDLE, 2'b01, 0, 0, 1, IDLE, 1);
    mem_dREN = 1; dhit = 1;
    apply(IDLE, 2'b11, 0, 0, 1, IDLE, 1);
    ex_Rs = 7; mem_Rw = 9; mem_dREN = 0; dhit = 0; wb_Rw = 0;
    apply(IDLE, 0, 0, 0, 1, IDLE, 1);
    ex_Rt = 4; wb_Rw = 4;
    apply(IDLE, 0, 2'b10, 0, 1, IDLE, 1);
    ex_Rs = 4; mem_Rw = 4;
    apply(IDLE, 2'b01, 2'b01, 0, 1, IDLE, 1);
    mem_RegWEN = 0;
    apply(IDLE, 2'b10, 2'b10, 0, 1, IDLE, 1);
    idle();
    id_Rs = 4; id_uses_rs = 1; mem_Rw = 4; mem_RegWEN = 1;
    apply(IDLE, 0, 0, 0, 1, LU, 1);
    idle();
    mem_dREN = 1; branch_taken = 1;
    apply(WT, 0, 0, 0, 1, WT, 2);
    dhit = 1;
    apply(BR, 0, 0, 0, 2, BR, 3);
    idle();
    apply(IDLE, 0, 0, 0, 2, IDLE, 3);
    ihit = 0;
    for (int i = 0; i < 3; i++) apply(IW, 0, 0, 0, 16'(2 + i), IW, 4'(3 + i));
    ihit = 1;
    apply(IDLE, 0, 0, 0, 5, IDLE, 6);
    branch_taken = 1; ihit = 0;
    apply(BR, 0, 0, 0, 5, BR, 6);
    idle();
    apply(IDLE, 0, 0, 0, 5, IDLE, 6);
    ihit = 0;
    for (int i = 0; i < 20; i++) apply(IW, 0, 0, 0, 16'(5 + i), IW, (6 + i > 15) ? 4'd15 : 4'(6 + i));
    idle();
    apply(IDLE, 0, 0, 0, 25, IDLE, 15);
    mem_halt = 1;
    apply(IDLE, 0, 0, 0, 25, IDLE, 15);
    mem_halt = 0; branch_taken = 1;
    apply(DR, 0, 0, 0, 25, DR, 15);
    branch_taken = 0; mem_dWEN = 1;
    apply(DRW, 0, 0, 0, 25, DRW, 15);
    mem_dWEN = 0; wb_halt = 1;
    apply(DR, 0, 0, 0, 25, DR, 15);
    wb_halt = 0; ihit = 0;
    apply(WT, 0, 0, 1, 25, WT, 15);
    ihit = 1;
    apply(WT, 0, 0, 1, 25, WT, 15);
    nRST = 0;
    apply(IDLE, 0, 0, 0, 0, IDLE, 0);
    nRST = 1;
    apply(IDLE, 0, 0, 0, 0, IDLE, 0);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
